// File: rtl/bitlet_bit_serializer.sv
// rtl/bitlet_bit_serializer.sv - emits the set-bit indices of each operand word, MSB first, one beat per cycle
// A residual register holds the word; each fired beat clears the bit its MSB locator found.
module bitlet_bit_serializer #(
  parameter int W  = 64,
  parameter int TW = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         in_data,
  input  logic [TW-1:0]        in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [$clog2(W)-1:0] out_idx,
  output logic                 out_zero,
  output logic                 out_last,
  output logic [$clog2(W):0]   out_seq,
  output logic [TW-1:0]        out_tag
);

  localparam int IW = $clog2(W);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    residual_q, residual_d;
  logic [IW:0]     seq_q, seq_d;
  logic [TW-1:0]   tag_q, tag_d;
  logic            zflag_q, zflag_d;

  logic [IW-1:0]   msb_idx;
  logic            one_hot;
  logic            run;
  logic            out_fire;
  logic            load;

  // Highest set bit wins because later iterations overwrite earlier ones.
  always_comb begin
    msb_idx = '0;
    for (int i = 0; i < W; i++) begin
      if (residual_q[i]) msb_idx = IW'(i);
    end
  end

  assign one_hot   = (residual_q != '0) && ((residual_q & (residual_q - W'(1))) == '0);
  assign run       = (state_q == RUN);

  assign out_valid = run;
  assign out_idx   = run ? msb_idx : '0;
  assign out_last  = run & (zflag_q | one_hot);
  assign out_zero  = run & zflag_q;
  assign out_seq   = run ? seq_q : '0;
  assign out_tag   = run ? tag_q : '0;

  assign out_fire  = run & out_ready;
  assign in_ready  = ~run | (out_fire & out_last);
  assign load      = in_valid & in_ready;

  always_comb begin
    state_d    = state_q;
    residual_d = residual_q;
    seq_d      = seq_q;
    tag_d      = tag_q;
    zflag_d    = zflag_q;
    if (load) begin
      // Covers both a fresh word in IDLE and the zero-bubble reload on a last beat.
      residual_d = in_data;
      tag_d      = in_tag;
      zflag_d    = (in_data == '0);
      seq_d      = '0;
      state_d    = RUN;
    end else if (out_fire) begin
      if (out_last) begin
        residual_d = '0;
        state_d    = IDLE;
      end else begin
        residual_d[msb_idx] = 1'b0;
        seq_d               = seq_q + {{IW{1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      residual_q <= '0;
      seq_q      <= '0;
      tag_q      <= '0;
      zflag_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      residual_q <= residual_d;
      seq_q      <= seq_d;
      tag_q      <= tag_d;
      zflag_q    <= zflag_d;
    end
  end

endmodule

// File: tb/tb_bitlet_bit_serializer.sv
// tb/tb_bitlet_bit_serializer.sv - randomized self-checking bench against a queue-based beat model
module tb_bitlet_bit_serializer;

  localparam int W  = 8;
  localparam int TW = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [IW-1:0] out_idx;
  logic          out_zero;
  logic          out_last;
  logic [IW:0]   out_seq;
  logic [TW-1:0] out_tag;

  bitlet_bit_serializer #(.W(W), .TW(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_zero(out_zero),
    .out_last(out_last), .out_seq(out_seq), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [IW:0]   seq;
    logic          last;
    logic          zero;
    logic [TW-1:0] tag;
  } beat_t;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [TW-1:0] tag;
  } word_t;

  beat_t exp_q[$];
  word_t pend_q[$];
  bit    ready_script[$];
  int    valid_pct = 100;
  int    ready_pct = 100;
  int    n_checks = 0;
  int    n_fail = 0;

  // Expected beats straight from the definition: every set bit, highest position first.
  task automatic expand_word(input logic [W-1:0] data, input logic [TW-1:0] tag);
    int k;
    int cnt;
    beat_t b;
    k = 0;
    for (int i = 0; i < W; i++) if (data[i]) k++;
    if (k == 0) begin
      b = '{idx: '0, seq: '0, last: 1'b1, zero: 1'b1, tag: tag};
      exp_q.push_back(b);
    end else begin
      cnt = 0;
      for (int i = W - 1; i >= 0; i--) begin
        if (data[i]) begin
          b = '{idx: IW'(i), seq: (IW+1)'(cnt), last: (cnt == k - 1), zero: 1'b0, tag: tag};
          exp_q.push_back(b);
          cnt++;
        end
      end
    end
  endtask

  task automatic push_word(input logic [W-1:0] data, input logic [TW-1:0] tag);
    word_t w;
    w = '{data: data, tag: tag};
    pend_q.push_back(w);
  endtask

  task automatic step();
    logic        exp_rdy;
    logic [18:0] got;
    logic [18:0] want;
    beat_t       h;
    @(posedge clk);
    #1;
    in_valid = (pend_q.size() > 0) && ($urandom_range(99) < valid_pct);
    if (in_valid) begin
      in_data = pend_q[0].data;
      in_tag  = pend_q[0].tag;
    end else begin
      in_data = W'($urandom);
      in_tag  = TW'($urandom);
    end
    if (ready_script.size() > 0) out_ready = ready_script.pop_front();
    else out_ready = ($urandom_range(99) < ready_pct);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      exp_rdy = 1'b1;
      got  = {17'd0, out_valid, in_ready};
      want = {17'd0, 1'b0, 1'b1};
    end else begin
      h = exp_q[0];
      exp_rdy = out_ready && h.last;
      got  = {out_valid, out_idx, out_zero, out_last, out_seq, out_tag, in_ready};
      want = {1'b1, h.idx, h.zero, h.last, h.seq, h.tag, exp_rdy};
    end
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL beat t=%0t got {v,idx,z,last,seq,tag,rdy}=%h required %h", $time, got, want);
    end
    if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
    if (in_valid && exp_rdy) begin
      expand_word(pend_q[0].data, pend_q[0].tag);
      void'(pend_q.pop_front());
    end
  endtask

  task automatic drain();
    int budget;
    budget = 4000;
    while ((pend_q.size() > 0 || exp_q.size() > 0) && budget > 0) begin
      step();
      budget--;
    end
    n_checks++;
    if (budget == 0) begin
      n_fail++;
      $display("FAIL drain_timeout pending=%0d beats=%0d required 0", pend_q.size(), exp_q.size());
      pend_q.delete();
      exp_q.delete();
    end
    step();
  endtask

  task automatic test_reset();
    logic [23:0] got;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    got = {out_valid, out_idx, out_zero, out_last, out_seq, out_tag, in_ready, 4'd0};
    n_checks++;
    if (got !== {19'd1, 4'd0} << 0 && got !== 24'h000010) begin
      n_fail++;
      $display("FAIL reset_outputs got %h required 000010", got);
    end
    rst_n = 1'b1;
    @(negedge clk);
    got = {out_valid, out_idx, out_zero, out_last, out_seq, out_tag, in_ready, 4'd0};
    n_checks++;
    if (got !== 24'h000010) begin
      n_fail++;
      $display("FAIL post_reset_idle got %h required 000010", got);
    end
  endtask

  task automatic test_pattern();
    valid_pct = 100; ready_pct = 100;
    push_word(8'b1010_0110, 8'h5A);
    drain();
  endtask

  task automatic test_zero();
    push_word(8'h00, 8'h33);
    drain();
  endtask

  task automatic test_all_ones();
    push_word(8'hFF, 8'hC3);
    drain();
  endtask

  task automatic test_back_to_back();
    valid_pct = 100; ready_pct = 100;
    push_word(8'h81, 8'hA1);
    push_word(8'h10, 8'hB2);
    push_word(8'h00, 8'hC4);
    push_word(8'h03, 8'hD8);
    drain();
  endtask

  task automatic test_backpressure();
    valid_pct = 100; ready_pct = 100;
    push_word(8'h24, 8'h77);
    ready_script = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    drain();
  endtask

  task automatic test_reset_mid_word();
    valid_pct = 100; ready_pct = 100;
    push_word(8'h92, 8'h11);
    step();
    step();
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL async_reset got {v,rdy}=%b required 01", {out_valid, in_ready});
    end
    exp_q.delete();
    pend_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    push_word(8'h0C, 8'h22);
    drain();
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      valid_pct = 40 + 20 * r;
      ready_pct = 100 - 20 * r;
      for (int n = 0; n < 30; n++) begin
        case ($urandom_range(4))
          0: push_word(8'h00, TW'($urandom));
          1: push_word(8'hFF, TW'($urandom));
          default: push_word(W'($urandom), TW'($urandom));
        endcase
      end
      drain();
    end
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_zero();
    test_all_ones();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
